// File: rtl/reg_stack_ctrl.sv
// rtl/reg_stack_ctrl.sv - push/pop sequencer for the 9-lane register-file context stack
// Drives the shared RAM address/write enable and tracks stack pointer, status and sticky errors.
module reg_stack_ctrl #(
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_req,
  input  logic              pop_req,
  input  logic              clr,
  output logic [ADDR_W-1:0] stack_addr,
  output logic              stack_wren,
  output logic              restore_en,
  output logic              done,
  output logic              busy,
  output logic [ADDR_W:0]   sp,
  output logic              full,
  output logic              empty,
  output logic              err_ovf,
  output logic              err_unf
);

  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [ADDR_W:0]  DEPTH_V  = (ADDR_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RD_LAT - 1);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W:0]     sp_q, sp_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   top_addr;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                wren_q, wren_d;
  logic                restore_q, restore_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  logic                ovf_q, ovf_d;
  logic                unf_q, unf_d;

  assign full  = (sp_q == DEPTH_V);
  assign empty = (sp_q == '0);
  // Low bits minus one also yields DEPTH-1 when sp == DEPTH == 2**ADDR_W.
  assign top_addr = sp_q[ADDR_W-1:0] - ADDR_W'(1);

  always_comb begin
    state_d   = state_q;
    sp_d      = sp_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    wren_d    = wren_q;
    restore_d = 1'b0;
    done_d    = 1'b0;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    if (clr) begin
      state_d = S_IDLE;
      sp_d    = '0;
      cnt_d   = '0;
      wren_d  = 1'b0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (push_req) begin
            if (full) begin
              ovf_d = 1'b1;
            end else begin
              addr_d  = sp_q[ADDR_W-1:0];
              wren_d  = 1'b1;
              state_d = S_WRITE;
            end
          end else if (pop_req) begin
            if (empty) begin
              unf_d = 1'b1;
            end else begin
              addr_d  = top_addr;
              cnt_d   = '0;
              state_d = S_READ;
            end
          end
        end
        S_WRITE: begin
          wren_d  = 1'b0;
          sp_d    = sp_q + (ADDR_W+1)'(1);
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
        S_READ: begin
          // Strobe lands in the cycle the RAM output carries the popped entry.
          if (cnt_q == LAST_CNT) begin
            restore_d = 1'b1;
            done_d    = 1'b1;
            sp_d      = sp_q - (ADDR_W+1)'(1);
            state_d   = S_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      sp_q      <= '0;
      addr_q    <= '0;
      cnt_q     <= '0;
      wren_q    <= 1'b0;
      restore_q <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sp_q      <= sp_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      wren_q    <= wren_d;
      restore_q <= restore_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end

  assign stack_addr = addr_q;
  assign stack_wren = wren_q;
  assign restore_en = restore_q;
  assign done       = done_q;
  assign busy       = busy_q;
  assign sp         = sp_q;
  assign err_ovf    = ovf_q;
  assign err_unf    = unf_q;

endmodule

// File: tb/tb_reg_stack_ctrl.sv
// tb/tb_reg_stack_ctrl.sv - self-checking bench for reg_stack_ctrl with RD_LAT=1 and RD_LAT=2
// Both instances share stimulus; a LIFO-level model predicts every output each cycle.
module tb_reg_stack_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic push_req = 1'b0, pop_req = 1'b0, clr = 1'b0;
  logic [7:0] wdata = 8'h00;

  logic [5:0] addr1, addr2;
  logic [6:0] sp1, sp2;
  logic wren1, wren2, rest1, rest2, done1, done2, busy1, busy2;
  logic full1, full2, empty1, empty2, ovf1, ovf2, unf1, unf2;

  always #5 clk = ~clk;

  reg_stack_ctrl #(.ADDR_W(6), .DEPTH(64), .RD_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .push_req(push_req), .pop_req(pop_req), .clr(clr),
    .stack_addr(addr1), .stack_wren(wren1), .restore_en(rest1), .done(done1),
    .busy(busy1), .sp(sp1), .full(full1), .empty(empty1),
    .err_ovf(ovf1), .err_unf(unf1));

  reg_stack_ctrl #(.ADDR_W(6), .DEPTH(64), .RD_LAT(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .push_req(push_req), .pop_req(pop_req), .clr(clr),
    .stack_addr(addr2), .stack_wren(wren2), .restore_en(rest2), .done(done2),
    .busy(busy2), .sp(sp2), .full(full2), .empty(empty2),
    .err_ovf(ovf2), .err_unf(unf2));

  // One lane of the stack RAM for each instance: unregistered q and registered q.
  logic [7:0] mem1 [64];
  logic [7:0] mem2 [64];
  logic [5:0] ar1 = 6'd0, ar2 = 6'd0;
  logic [7:0] q2r = 8'h00;
  wire  [7:0] q1 = mem1[ar1];
  wire  [7:0] q2 = q2r;

  always @(posedge clk) begin
    if (wren1) mem1[addr1] <= wdata;
    ar1 <= addr1;
    if (wren2) mem2[addr2] <= wdata;
    ar2 <= addr2;
    q2r <= mem2[ar2];
  end

  // Reference model: stack contents plus the in-flight operation and its remaining cycles.
  int         lat_k [2] = '{1, 2};
  int         m_sp [2], m_op [2], m_rem [2];
  logic [5:0] m_addr [2];
  logic       m_wren [2], m_rest [2], m_done [2], m_ovf [2], m_unf [2];
  logic [7:0] m_pend [2], m_exp [2];
  logic [7:0] m_stk [2][64];

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  task automatic model_step(input int k);
    m_rest[k] = 1'b0;
    m_done[k] = 1'b0;
    if (clr) begin
      m_op[k] = 0; m_sp[k] = 0; m_wren[k] = 1'b0; m_ovf[k] = 1'b0; m_unf[k] = 1'b0;
    end else if (m_op[k] == 0) begin
      if (push_req) begin
        if (m_sp[k] == 64) m_ovf[k] = 1'b1;
        else begin
          m_addr[k] = 6'(m_sp[k]); m_wren[k] = 1'b1; m_op[k] = 1; m_rem[k] = 1; m_pend[k] = wdata;
        end
      end else if (pop_req) begin
        if (m_sp[k] == 0) m_unf[k] = 1'b1;
        else begin
          m_addr[k] = 6'(m_sp[k] - 1); m_op[k] = 2; m_rem[k] = lat_k[k];
        end
      end
    end else begin
      m_rem[k] = m_rem[k] - 1;
      if (m_rem[k] == 0) begin
        if (m_op[k] == 1) begin
          m_wren[k] = 1'b0;
          m_stk[k][m_sp[k]] = m_pend[k];
          m_sp[k] = m_sp[k] + 1;
        end else begin
          m_sp[k] = m_sp[k] - 1;
          m_exp[k] = m_stk[k][m_sp[k]];
          m_rest[k] = 1'b1;
        end
        m_done[k] = 1'b1;
        m_op[k] = 0;
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_sp[k] = 0; m_op[k] = 0; m_rem[k] = 0; m_addr[k] = 6'd0;
        m_wren[k] = 1'b0; m_rest[k] = 1'b0; m_done[k] = 1'b0; m_ovf[k] = 1'b0; m_unf[k] = 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++) model_step(k);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_dut(input int k, input logic [5:0] a, input logic w, input logic r,
                         input logic d, input logic b, input logic [6:0] s, input logic f,
                         input logic e, input logic o, input logic u, input logic [7:0] q);
    string p;
    p = $sformatf("dut%0d", k + 1);
    chk({p, " stack_addr"}, 32'(a), 32'(m_addr[k]));
    chk({p, " stack_wren"}, 32'(w), 32'(m_wren[k]));
    chk({p, " restore_en"}, 32'(r), 32'(m_rest[k]));
    chk({p, " done"},       32'(d), 32'(m_done[k]));
    chk({p, " busy"},       32'(b), 32'(m_op[k] != 0));
    chk({p, " sp"},         32'(s), 32'(m_sp[k]));
    chk({p, " full"},       32'(f), 32'(m_sp[k] == 64));
    chk({p, " empty"},      32'(e), 32'(m_sp[k] == 0));
    chk({p, " err_ovf"},    32'(o), 32'(m_ovf[k]));
    chk({p, " err_unf"},    32'(u), 32'(m_unf[k]));
    if (m_rest[k]) chk({p, " restored data"}, 32'(q), 32'(m_exp[k]));
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      cmp_dut(0, addr1, wren1, rest1, done1, busy1, sp1, full1, empty1, ovf1, unf1, q1);
      cmp_dut(1, addr2, wren2, rest2, done2, busy2, sp2, full2, empty2, ovf2, unf2, q2);
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push_one(input logic [7:0] v);
    push_req = 1'b1; wdata = v;
    step();
    push_req = 1'b0;
    step();
    step();
  endtask

  initial begin
    int r;
    int bias;
    step(); step();
    rst_n = 1'b1;
    chk_on = 1'b1;
    chk("reset sp", 32'(sp1), 32'd0);
    chk("reset empty", 32'(empty1), 32'd1);
    chk("reset full", 32'(full1), 32'd0);
    chk("reset busy", 32'(busy1), 32'd0);

    // First push: address 0 written at E0, done/sp one cycle later.
    push_req = 1'b1; wdata = 8'hA5;
    step();
    push_req = 1'b0;
    chk("push E0 addr", 32'(addr1), 32'd0);
    chk("push E0 wren", 32'(wren1), 32'd1);
    step();
    chk("push E1 wren", 32'(wren1), 32'd0);
    chk("push E1 done", 32'(done1), 32'd1);
    chk("push E1 sp", 32'(sp1), 32'd1);
    chk("push E1 empty", 32'(empty1), 32'd0);
    step();
    push_one(8'h3C);

    // Two pops: LIFO order, RD_LAT=1 restores one cycle before RD_LAT=2.
    pop_req = 1'b1;
    step();
    pop_req = 1'b0;
    chk("pop1 E0 addr", 32'(addr1), 32'd1);
    chk("pop1 E0 addr lat2", 32'(addr2), 32'd1);
    step();
    chk("pop1 restore lat1", 32'(rest1), 32'd1);
    chk("pop1 data lat1", 32'(q1), 32'h3C);
    chk("pop1 no restore yet lat2", 32'(rest2), 32'd0);
    step();
    chk("pop1 restore lat2", 32'(rest2), 32'd1);
    chk("pop1 data lat2", 32'(q2), 32'h3C);
    pop_req = 1'b1;
    step();
    pop_req = 1'b0;
    chk("pop2 E0 addr", 32'(addr1), 32'd0);
    step();
    chk("pop2 data lat1", 32'(q1), 32'hA5);
    step();
    chk("pop2 data lat2", 32'(q2), 32'hA5);
    chk("pop2 final sp", 32'(sp2), 32'd0);
    chk("pop2 final empty", 32'(empty1), 32'd1);
    step();

    // push and pop together with sp=3, then a pop during WRITE.
    for (int i = 0; i < 3; i++) push_one(8'(i + 1));
    push_req = 1'b1; pop_req = 1'b1; wdata = 8'h77;
    step();
    push_req = 1'b0;
    chk("push wins addr", 32'(addr1), 32'd3);
    chk("push wins wren", 32'(wren1), 32'd1);
    step();
    pop_req = 1'b0;
    chk("push wins done", 32'(done1), 32'd1);
    chk("push wins sp", 32'(sp1), 32'd4);
    step();
    chk("ignored pop done", 32'(done1), 32'd0);
    chk("ignored pop busy", 32'(busy1), 32'd0);
    chk("ignored pop sp", 32'(sp1), 32'd4);

    // Pop from empty.
    clr = 1'b1;
    step();
    clr = 1'b0;
    pop_req = 1'b1;
    step();
    pop_req = 1'b0;
    chk("underflow err", 32'(unf1), 32'd1);
    chk("underflow busy", 32'(busy1), 32'd0);
    chk("underflow done", 32'(done1), 32'd0);
    step();
    chk("underflow restore", 32'(rest1), 32'd0);
    chk("underflow sticky", 32'(unf1), 32'd1);

    // RD_LAT=2 pop, then clr aborting a second pop.
    clr = 1'b1;
    step();
    clr = 1'b0;
    push_one(8'hA1);
    push_one(8'hB2);
    pop_req = 1'b1;
    step();
    pop_req = 1'b0;
    chk("lat2 E0 addr", 32'(addr2), 32'd1);
    step();
    chk("lat2 after E1 restore", 32'(rest2), 32'd0);
    step();
    chk("lat2 after E2 restore", 32'(rest2), 32'd1);
    chk("lat2 after E2 data", 32'(q2), 32'hB2);
    step();
    pop_req = 1'b1;
    step();
    pop_req = 1'b0;
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("abort restore", 32'(rest2), 32'd0);
    chk("abort done", 32'(done2), 32'd0);
    chk("abort sp", 32'(sp2), 32'd0);
    step();
    chk("abort late restore", 32'(rest2), 32'd0);
    chk("abort busy", 32'(busy2), 32'd0);

    // Fill to DEPTH, then overflow.
    for (int i = 0; i < 64; i++) begin
      push_req = 1'b1; wdata = 8'($urandom);
      step();
      push_req = 1'b0;
      step();
    end
    step();
    chk("fill sp", 32'(sp1), 32'd64);
    chk("fill full", 32'(full1), 32'd1);
    push_req = 1'b1;
    step();
    push_req = 1'b0;
    chk("overflow wren", 32'(wren1), 32'd0);
    chk("overflow err", 32'(ovf1), 32'd1);
    chk("overflow sp", 32'(sp1), 32'd64);
    chk("overflow busy", 32'(busy1), 32'd0);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr sp", 32'(sp1), 32'd0);
    chk("clr err_ovf", 32'(ovf1), 32'd0);

    // Randomized traffic with push-heavy and pop-heavy phases.
    for (int c = 0; c < 4000; c++) begin
      bias = ((c / 500) % 2 == 0) ? 45 : 20;
      r = $urandom_range(0, 99);
      push_req = (r < bias);
      pop_req  = (r >= bias - 10) && (r < bias + 35);
      clr      = ($urandom_range(0, 149) == 0);
      rst_n    = ($urandom_range(0, 799) != 0);
      if (push_req && m_op[0] == 0 && m_op[1] == 0) wdata = 8'($urandom);
      step();
    end
    push_req = 1'b0; pop_req = 1'b0; clr = 1'b0; rst_n = 1'b1;
    step(); step();
    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
